// File: rtl/parallel_to_serial_pkg.sv
// Shared serial-link definitions: link state encoding and counter sizing helper.
package parallel_to_serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } link_state_t;

  function automatic int cnt_width(input int size);
    return ($clog2(size) < 1) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/parallel_to_serial_if.sv
// Load handshake plus serial bit stream between a word producer and the transmitter.
interface parallel_to_serial_if #(
  parameter int data_size = 64
);

  logic [data_size-1:0] data;
  logic                 load_valid;
  logic                 load_ready;
  logic                 hold;
  logic                 data_out;
  logic                 en;
  logic                 done;

  modport master (
    output data, load_valid, hold,
    input  load_ready, data_out, en, done
  );

  modport slave (
    input  data, load_valid, hold,
    output load_ready, data_out, en, done
  );

endinterface

// File: rtl/parallel_to_serial.sv
// Word-to-bit transmitter: MSB first, first bit the cycle after load, HOLD pauses shifting.
// Ready only when idle or on the last bit, so back-to-back words stream with no gap.
module parallel_to_serial
  import parallel_to_serial_pkg::*;
#(
  parameter int data_size = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  parallel_to_serial_if.slave   link
);

  localparam int                cnt_w    = cnt_width(data_size);
  localparam logic [cnt_w-1:0]  last_cnt = cnt_w'(data_size - 1);

  link_state_t          state;
  logic [data_size-1:0] sreg;
  logic [cnt_w-1:0]     cnt;

  logic shifting;
  logic last_bit;
  logic accept;

  assign shifting = (state == SHIFT) && !link.hold;
  assign last_bit = (cnt == last_cnt);
  assign accept   = link.load_valid && link.load_ready;

  // Ready is forced low while in reset; the registers alone would read as IDLE.
  assign link.done       = shifting && last_bit;
  assign link.load_ready = rst && ((state == IDLE) || link.done);
  assign link.en         = shifting;
  assign link.data_out   = (state == SHIFT) && sreg[data_size-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sreg  <= link.data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shifting) begin
            if (last_bit) begin
              if (accept) begin
                sreg <= link.data;
              end else begin
                sreg  <= '0;
                state <= IDLE;
              end
              cnt <= '0;
            end else begin
              sreg <= {sreg[data_size-2:0], 1'b0};
              cnt  <= cnt + cnt_w'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench: 64-bit and 2-bit transmitters with a behavioural receiver capturing bits on EN.
module tb_parallel_to_serial;

  logic clk;
  logic rst;
  int   tests_run;
  int   fails;

  parallel_to_serial_if #(.data_size(64)) l64 ();
  parallel_to_serial_if #(.data_size(2))  l2  ();

  parallel_to_serial #(.data_size(64)) dut64 (
    .clk  (clk),
    .rst  (rst),
    .link (l64.slave)
  );

  parallel_to_serial #(.data_size(2)) dut2 (
    .clk  (clk),
    .rst  (rst),
    .link (l2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({l64.load_ready, l64.en, l64.data_out, l64.done} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outputs_64: got rdy/en/do/done=%b required 0000",
               {l64.load_ready, l64.en, l64.data_out, l64.done});
    end
    tests_run++;
    if ({l2.load_ready, l2.en, l2.data_out, l2.done} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outputs_2: got rdy/en/do/done=%b required 0000",
               {l2.load_ready, l2.en, l2.data_out, l2.done});
    end
    step();
    step();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({l64.load_ready, l64.en, l64.data_out, l64.done} !== 4'b1000) begin
      fails++;
      $display("FAIL idle_outputs: got rdy/en/do/done=%b required 1000",
               {l64.load_ready, l64.en, l64.data_out, l64.done});
    end
    step();
  endtask

  task automatic test_loopback();
    logic [63:0] w;
    logic [63:0] rx;
    int en_err, rdy_err, done_cnt, done_at;
    w = 64'hDEAD_BEEF_0123_4567;
    rx = '0; en_err = 0; rdy_err = 0; done_cnt = 0; done_at = 0;
    l64.data = w;
    l64.load_valid = 1'b1;
    l64.hold = 1'b0;
    #1;
    tests_run++;
    if (l64.load_ready !== 1'b1) begin
      fails++;
      $display("FAIL loopback_ready_idle: got %b required 1", l64.load_ready);
    end
    step();
    l64.load_valid = 1'b0;
    l64.data = '0;
    for (int c = 1; c <= 64; c++) begin
      #1;
      if (l64.en !== 1'b1) en_err++;
      else rx = {rx[62:0], l64.data_out};
      if (l64.done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (l64.load_ready !== (c == 64)) rdy_err++;
      step();
    end
    tests_run++;
    if (rx !== w) begin
      fails++;
      $display("FAIL loopback_word: got %h required %h", rx, w);
    end
    tests_run++;
    if (done_cnt !== 1 || done_at !== 64) begin
      fails++;
      $display("FAIL loopback_done: got %0d pulses at cycle %0d required 1 at cycle 64", done_cnt, done_at);
    end
    tests_run++;
    if (en_err !== 0 || rdy_err !== 0) begin
      fails++;
      $display("FAIL loopback_en_ready: got %0d en errors %0d ready errors required 0 and 0", en_err, rdy_err);
    end
    #1;
    tests_run++;
    if ({l64.load_ready, l64.en, l64.data_out} !== 3'b100) begin
      fails++;
      $display("FAIL loopback_return_idle: got rdy/en/do=%b required 100",
               {l64.load_ready, l64.en, l64.data_out});
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [63:0] rx_a, rx_b;
    int en_err, rdy_err, done_cnt;
    rx_a = '0; rx_b = '0; en_err = 0; rdy_err = 0; done_cnt = 0;
    l64.data = 64'hAAAA_AAAA_AAAA_AAAA;
    l64.load_valid = 1'b1;
    step();
    l64.data = 64'h5555_5555_5555_5555;
    for (int c = 1; c <= 128; c++) begin
      #1;
      if (l64.en !== 1'b1) en_err++;
      else if (c <= 64) rx_a = {rx_a[62:0], l64.data_out};
      else rx_b = {rx_b[62:0], l64.data_out};
      if (l64.done === 1'b1) done_cnt++;
      if (l64.load_ready !== (c == 64 || c == 128)) rdy_err++;
      step();
      if (c == 64) l64.load_valid = 1'b0;
    end
    tests_run++;
    if (rx_a !== 64'hAAAA_AAAA_AAAA_AAAA || rx_b !== 64'h5555_5555_5555_5555) begin
      fails++;
      $display("FAIL b2b_words: got %h %h required aaaaaaaaaaaaaaaa 5555555555555555", rx_a, rx_b);
    end
    tests_run++;
    if (en_err !== 0 || done_cnt !== 2) begin
      fails++;
      $display("FAIL b2b_stream: got %0d en gaps %0d done pulses required 0 gaps 2 pulses", en_err, done_cnt);
    end
    tests_run++;
    if (rdy_err !== 0) begin
      fails++;
      $display("FAIL b2b_ready: got %0d ready errors required 0", rdy_err);
    end
    #1;
    tests_run++;
    if (l64.en !== 1'b0) begin
      fails++;
      $display("FAIL b2b_end_idle: got en=%b required 0", l64.en);
    end
    step();
  endtask

  task automatic test_hold();
    logic [63:0] w;
    logic [63:0] rx;
    int sent, err, done_at;
    logic exp_en;
    w = 64'h0123_4567_89AB_CDEF;
    rx = '0; sent = 0; err = 0; done_at = 0;
    l64.data = w;
    l64.load_valid = 1'b1;
    step();
    l64.load_valid = 1'b0;
    for (int c = 1; c <= 69; c++) begin
      l64.hold = (c >= 10 && c <= 14);
      exp_en = !(c >= 10 && c <= 14);
      #1;
      if (l64.en !== exp_en) err++;
      if (l64.data_out !== w[63 - sent]) err++;
      if (l64.load_ready !== (c == 69)) err++;
      if (l64.done === 1'b1) done_at = c;
      if (l64.en === 1'b1) begin
        rx = {rx[62:0], l64.data_out};
        sent++;
      end
      step();
    end
    l64.hold = 1'b0;
    tests_run++;
    if (err !== 0) begin
      fails++;
      $display("FAIL hold_cycles: got %0d en/data_out/ready errors required 0", err);
    end
    tests_run++;
    if (done_at !== 69) begin
      fails++;
      $display("FAIL hold_done_cycle: got %0d required 69", done_at);
    end
    tests_run++;
    if (rx !== w) begin
      fails++;
      $display("FAIL hold_word: got %h required %h", rx, w);
    end
    step();
  endtask

  task automatic test_reset_mid_word();
    logic [63:0] rx;
    int err, done_at;
    rx = '0; err = 0; done_at = 0;
    l64.data = 64'hFFFF_FFFF_FFFF_FFFF;
    l64.load_valid = 1'b1;
    step();
    l64.load_valid = 1'b0;
    for (int c = 1; c <= 20; c++) step();
    #2;
    tests_run++;
    if ({l64.en, l64.data_out, l64.load_ready} !== 3'b110) begin
      fails++;
      $display("FAIL midword_before_reset: got en/do/rdy=%b required 110",
               {l64.en, l64.data_out, l64.load_ready});
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if ({l64.en, l64.data_out, l64.load_ready, l64.done} !== 4'b0000) begin
      fails++;
      $display("FAIL midword_async_reset: got en/do/rdy/done=%b required 0000",
               {l64.en, l64.data_out, l64.load_ready, l64.done});
    end
    step();
    rst = 1'b1;
    l64.data = 64'h0000_0000_0000_0001;
    l64.load_valid = 1'b1;
    #1;
    tests_run++;
    if (l64.load_ready !== 1'b1 || l64.en !== 1'b0) begin
      fails++;
      $display("FAIL midword_ready_after_reset: got rdy=%b en=%b required 1 0", l64.load_ready, l64.en);
    end
    step();
    l64.load_valid = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      #1;
      if (l64.en !== 1'b1) err++;
      else rx = {rx[62:0], l64.data_out};
      if (l64.done === 1'b1) done_at = c;
      step();
    end
    tests_run++;
    if (rx !== 64'h1 || err !== 0 || done_at !== 64) begin
      fails++;
      $display("FAIL midword_reload: got word %h en errs %0d done at %0d required 0000000000000001 0 64",
               rx, err, done_at);
    end
    step();
  endtask

  task automatic test_ignored_offer();
    logic [63:0] rx_a, rx_b;
    int rdy_err, en_err;
    rx_a = '0; rx_b = '0; rdy_err = 0; en_err = 0;
    l64.data = 64'h0F0F_0F0F_0F0F_0F0F;
    l64.load_valid = 1'b1;
    step();
    l64.load_valid = 1'b0;
    for (int c = 1; c <= 128; c++) begin
      if (c == 5) begin
        l64.data = 64'h1234_5678_9ABC_DEF0;
        l64.load_valid = 1'b1;
      end
      #1;
      if (l64.en !== 1'b1) en_err++;
      else if (c <= 64) rx_a = {rx_a[62:0], l64.data_out};
      else rx_b = {rx_b[62:0], l64.data_out};
      if (l64.load_ready !== (c == 64 || c == 128)) rdy_err++;
      step();
      if (c == 64) l64.load_valid = 1'b0;
    end
    tests_run++;
    if (rx_a !== 64'h0F0F_0F0F_0F0F_0F0F) begin
      fails++;
      $display("FAIL ignored_inflight_word: got %h required 0f0f0f0f0f0f0f0f", rx_a);
    end
    tests_run++;
    if (rx_b !== 64'h1234_5678_9ABC_DEF0 || en_err !== 0) begin
      fails++;
      $display("FAIL ignored_offer_word: got %h en errs %0d required 123456789abcdef0 0", rx_b, en_err);
    end
    tests_run++;
    if (rdy_err !== 0) begin
      fails++;
      $display("FAIL ignored_ready: got %0d ready errors required 0", rdy_err);
    end
    step();
  endtask

  task automatic test_width2();
    l2.data = 2'b10;
    l2.load_valid = 1'b1;
    #1;
    tests_run++;
    if (l2.load_ready !== 1'b1) begin
      fails++;
      $display("FAIL w2_ready_idle: got %b required 1", l2.load_ready);
    end
    step();
    l2.load_valid = 1'b0;
    l2.data = 2'b00;
    #1;
    tests_run++;
    if ({l2.en, l2.data_out, l2.done, l2.load_ready} !== 4'b1100) begin
      fails++;
      $display("FAIL w2_bit1: got en/do/done/rdy=%b required 1100",
               {l2.en, l2.data_out, l2.done, l2.load_ready});
    end
    step();
    #1;
    tests_run++;
    if ({l2.en, l2.data_out, l2.done, l2.load_ready} !== 4'b1011) begin
      fails++;
      $display("FAIL w2_bit0: got en/do/done/rdy=%b required 1011",
               {l2.en, l2.data_out, l2.done, l2.load_ready});
    end
    step();
    #1;
    tests_run++;
    if ({l2.en, l2.data_out, l2.done, l2.load_ready} !== 4'b0001) begin
      fails++;
      $display("FAIL w2_idle: got en/do/done/rdy=%b required 0001",
               {l2.en, l2.data_out, l2.done, l2.load_ready});
    end
    step();
  endtask

  initial begin
    tests_run = 0;
    fails = 0;
    rst = 1'b0;
    l64.data = '0;
    l64.load_valid = 1'b0;
    l64.hold = 1'b0;
    l2.data = '0;
    l2.load_valid = 1'b0;
    l2.hold = 1'b0;
    test_reset();
    test_loopback();
    test_back_to_back();
    test_hold();
    test_reset_mid_word();
    test_ignored_offer();
    test_width2();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/parallel_to_serial.md
PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

Interface
REQ-001 Parameter data_size, default 64: word width in bits; legal range >= 2.
REQ-002 CLK  in  1  sole clock; all state changes on rising edge.
REQ-003 RST  in  1  asynchronous, active-low reset; low = in reset.
REQ-004 DATA  in  data_size  parallel word to transmit; sampled only on load acceptance.
REQ-005 LOAD_VALID  in  1  producer offers DATA this cycle.
REQ-006 LOAD_READY  out  1  block accepts DATA this cycle; load occurs when LOAD_VALID && LOAD_READY at a rising edge.
REQ-007 HOLD  in  1  pause request; freezes shifting while high.
REQ-008 DATA_OUT  out  1  current serial bit, MSB first; drives the paired receiver's data input.
REQ-009 EN  out  1  bit-valid strobe; drives the paired receiver's enable; one bit is consumed per cycle with EN high.
REQ-010 DONE  out  1  single-cycle pulse, high during the cycle carrying bit 0 of a word while EN is high.

Function
REQ-011 States: IDLE (no word) and SHIFT (word in progress); no other states.
REQ-012 IDLE: LOAD_READY=1, EN=0, DATA_OUT=0, DONE=0.
REQ-013 IDLE, load accepted: shift register <= DATA, bit counter <= 0, next state SHIFT.
REQ-014 Latency: first bit (DATA[data_size-1]) appears on DATA_OUT with EN=1 in the cycle after acceptance.
REQ-015 SHIFT: DATA_OUT = shift register MSB; EN = !HOLD; both derived from registered state only, not from DATA or LOAD_VALID.
REQ-016 SHIFT, EN=1: register shifts left one place (zero fill), counter increments by 1.
REQ-017 SHIFT, HOLD=1: register, counter, DATA_OUT unchanged; EN=0; DONE=0.
REQ-018 Counter width $clog2(data_size); last bit when counter == data_size-1; no wrap beyond that value.
REQ-019 DONE = (state==SHIFT) && EN && (counter == data_size-1).
REQ-020 LOAD_READY in SHIFT = DONE (ready only in the last-bit cycle, never while HOLD is high).
REQ-021 Last-bit cycle, load accepted: reload register and zero counter; state stays SHIFT; new word's MSB follows with no gap cycle.
REQ-022 Last-bit cycle, no load: next state IDLE.
REQ-023 LOAD_VALID while LOAD_READY=0: ignored; DATA not sampled; producer must hold its offer.
REQ-024 Exactly data_size EN-high cycles per accepted word, in order data_size-1 down to 0.

Reset
REQ-025 RST low: state IDLE, shift register 0, counter 0, immediately and independent of CLK.
REQ-026 While RST low: DATA_OUT=0, EN=0, DONE=0, LOAD_READY=0.
REQ-027 Reset mid-word: partial word discarded; no resumption; block ready for a fresh load on the first edge after RST rises.

Structure
REQ-028 State enum (IDLE, SHIFT) lives in the shared serial-link package used by both transmitter and receiver.
REQ-029 Single flat module; no sub-module; counter and shift register are inline.
REQ-030 No latches; all sequential logic in one clocked process with async reset; outputs as continuous assignments from registers.

Verification
REQ-031 Loopback: data_size=64, load 0xDEADBEEF01234567, HOLD=0 -> paired receiver holds 0xDEADBEEF01234567 after 64 EN cycles; DONE high in cycle 64 only.
REQ-032 Back-to-back: LOAD_VALID held with 0xAAAA...AA then 0x5555...55 -> 128 consecutive EN cycles, no gap, single LOAD_READY in each last-bit cycle, receiver holds each word correctly.
REQ-033 HOLD: HOLD high cycles 10-14 of a word -> EN low for exactly those 5 cycles, DATA_OUT frozen, total 69 cycles to DONE, receiver word correct.
REQ-034 Reset mid-word: RST low after 20 bits -> EN, DATA_OUT, LOAD_READY go 0 without a clock edge; next load of 0x0000000000000001 transmits fully and correctly.
REQ-035 Ignored offer: LOAD_VALID with a different DATA during SHIFT (not last bit) -> in-flight word unaffected; offer accepted only at the last bit.
REQ-036 Width edge: data_size=2, load 2'b10 -> DATA_OUT 1 then 0, DONE on second EN cycle, return to IDLE.
